// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if : user-side delivery bundle of the UART receiver  | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface uart_rx_if #(
  parameter int P_UART_DATA_WIDTH = 8
);
  logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data;
  logic                         o_user_rx_valid;
  logic                         o_user_rx_check_err;
  logic                         o_user_rx_frame_err;

  modport master (
    output o_user_rx_data,
    output o_user_rx_valid,
    output o_user_rx_check_err,
    output o_user_rx_frame_err
  );

  modport slave (
    input o_user_rx_data,
    input o_user_rx_valid,
    input o_user_rx_check_err,
    input o_user_rx_frame_err
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : edge-started UART receiver, LSB first, parity/stop checks | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx #(
  parameter int P_SYSTEM_CLK      = 50_000_000,
  parameter int P_UART_BUADRATE   = 9600,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK      = 0
) (
  input  wire logic  i_clk,
  input  wire logic  i_rst,
  input  wire logic  i_uart_rx,
  uart_rx_if.master  user_if
);

  localparam int          c_baud_div   = P_SYSTEM_CLK / P_UART_BUADRATE;
  localparam int          c_half_div   = c_baud_div / 2;
  localparam logic [15:0] c_div_m1     = 16'(c_baud_div - 1);
  localparam logic [15:0] c_half_m1    = 16'(c_half_div - 1);
  localparam logic [2:0]  c_data_last  = 3'(P_UART_DATA_WIDTH - 1);
  localparam logic [2:0]  c_stop_last  = 3'(P_UART_STOP_WIDTH - 1);
  localparam bit          c_has_parity = (P_UART_CHECK != 0);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHECK = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  state_t                       state_q, state_d;
  logic                         rx_sync1_q, rx_sync1_d;
  logic                         rx_sync2_q, rx_sync2_d;
  logic                         rx_prev_q, rx_prev_d;
  logic [15:0]                  baud_cnt_q, baud_cnt_d;
  logic [2:0]                   bit_cnt_q, bit_cnt_d;
  logic [P_UART_DATA_WIDTH-1:0] shift_q, shift_d;
  logic                         parity_bit_q, parity_bit_d;
  logic                         frame_acc_q, frame_acc_d;
  logic                         done_q, done_d;
  logic [P_UART_DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                         rx_valid_q, rx_valid_d;
  logic                         check_err_q, check_err_d;
  logic                         frame_err_q, frame_err_d;

  logic w_fall;
  logic w_tick;
  logic w_par_xor;

  always_comb begin
    state_d      = state_q;
    rx_sync1_d   = i_uart_rx;
    rx_sync2_d   = rx_sync1_q;
    rx_prev_d    = rx_sync2_q;
    baud_cnt_d   = baud_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_bit_d = parity_bit_q;
    frame_acc_d  = frame_acc_q;
    done_d       = 1'b0;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    check_err_d  = check_err_q;
    frame_err_d  = frame_err_q;

    w_fall    = rx_prev_q & ~rx_sync2_q;
    w_tick    = (baud_cnt_q == c_div_m1);
    w_par_xor = (^shift_q) ^ parity_bit_q;

    case (state_q)
      ST_IDLE: begin
        baud_cnt_d  = '0;
        bit_cnt_d   = '0;
        frame_acc_d = 1'b0;
        if (w_fall) state_d = ST_START;
      end
      ST_START: begin
        if (baud_cnt_q == c_half_m1) begin
          baud_cnt_d = '0;
          // A start that is high again at mid-bit is treated as line noise.
          state_d    = rx_sync2_q ? ST_IDLE : ST_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          baud_cnt_d = '0;
          shift_d    = {rx_sync2_q, shift_q[P_UART_DATA_WIDTH-1:1]};
          if (bit_cnt_q == c_data_last) begin
            bit_cnt_d = '0;
            state_d   = c_has_parity ? ST_CHECK : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      ST_CHECK: begin
        if (w_tick) begin
          baud_cnt_d   = '0;
          parity_bit_d = rx_sync2_q;
          state_d      = ST_STOP;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          baud_cnt_d = '0;
          if (!rx_sync2_q) frame_acc_d = 1'b1;
          if (bit_cnt_q == c_stop_last) begin
            bit_cnt_d = '0;
            done_d    = 1'b1;
            // Leaving mid-stop-bit leaves half a bit to catch the next start edge.
            state_d   = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (done_q) begin
      rx_valid_d  = 1'b1;
      rx_data_d   = shift_q;
      frame_err_d = frame_acc_q;
      if (P_UART_CHECK == 2)      check_err_d = w_par_xor;
      else if (P_UART_CHECK == 1) check_err_d = ~w_par_xor;
      else                        check_err_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      rx_sync1_q   <= 1'b1;
      rx_sync2_q   <= 1'b1;
      rx_prev_q    <= 1'b1;
      baud_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_bit_q <= 1'b0;
      frame_acc_q  <= 1'b0;
      done_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      check_err_q  <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_sync1_q   <= rx_sync1_d;
      rx_sync2_q   <= rx_sync2_d;
      rx_prev_q    <= rx_prev_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_bit_q <= parity_bit_d;
      frame_acc_q  <= frame_acc_d;
      done_q       <= done_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      check_err_q  <= check_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign user_if.o_user_rx_data      = rx_data_q;
  assign user_if.o_user_rx_valid     = rx_valid_q;
  assign user_if.o_user_rx_check_err = check_err_q;
  assign user_if.o_user_rx_frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx : scoreboard bench for uart_rx in 8N1, 8E1, 8O1 and 8N2 setups | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;

  localparam int c_clk_hz = 1_000_000;
  localparam int c_baud   = 100_000;
  localparam int c_d      = 10;
  localparam int c_h      = 5;

  typedef struct {
    logic [7:0] data;
    logic       ce;
    logic       fe;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       line [4];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  exp_t       sb [4][$];

  logic       mv [4];
  logic [7:0] md [4];
  logic       mce [4];
  logic       mfe [4];

  uart_rx_if #(.P_UART_DATA_WIDTH(8)) if_n1 ();
  uart_rx_if #(.P_UART_DATA_WIDTH(8)) if_e1 ();
  uart_rx_if #(.P_UART_DATA_WIDTH(8)) if_o1 ();
  uart_rx_if #(.P_UART_DATA_WIDTH(8)) if_n2 ();

  uart_rx #(.P_SYSTEM_CLK(c_clk_hz), .P_UART_BUADRATE(c_baud), .P_UART_DATA_WIDTH(8),
            .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0))
    dut_n1 (.i_clk(clk), .i_rst(rst), .i_uart_rx(line[0]), .user_if(if_n1));
  uart_rx #(.P_SYSTEM_CLK(c_clk_hz), .P_UART_BUADRATE(c_baud), .P_UART_DATA_WIDTH(8),
            .P_UART_STOP_WIDTH(1), .P_UART_CHECK(2))
    dut_e1 (.i_clk(clk), .i_rst(rst), .i_uart_rx(line[1]), .user_if(if_e1));
  uart_rx #(.P_SYSTEM_CLK(c_clk_hz), .P_UART_BUADRATE(c_baud), .P_UART_DATA_WIDTH(8),
            .P_UART_STOP_WIDTH(1), .P_UART_CHECK(1))
    dut_o1 (.i_clk(clk), .i_rst(rst), .i_uart_rx(line[2]), .user_if(if_o1));
  uart_rx #(.P_SYSTEM_CLK(c_clk_hz), .P_UART_BUADRATE(c_baud), .P_UART_DATA_WIDTH(8),
            .P_UART_STOP_WIDTH(2), .P_UART_CHECK(0))
    dut_n2 (.i_clk(clk), .i_rst(rst), .i_uart_rx(line[3]), .user_if(if_n2));

  assign mv[0] = if_n1.o_user_rx_valid;  assign md[0] = if_n1.o_user_rx_data;
  assign mce[0] = if_n1.o_user_rx_check_err; assign mfe[0] = if_n1.o_user_rx_frame_err;
  assign mv[1] = if_e1.o_user_rx_valid;  assign md[1] = if_e1.o_user_rx_data;
  assign mce[1] = if_e1.o_user_rx_check_err; assign mfe[1] = if_e1.o_user_rx_frame_err;
  assign mv[2] = if_o1.o_user_rx_valid;  assign md[2] = if_o1.o_user_rx_data;
  assign mce[2] = if_o1.o_user_rx_check_err; assign mfe[2] = if_o1.o_user_rx_frame_err;
  assign mv[3] = if_n2.o_user_rx_valid;  assign md[3] = if_n2.o_user_rx_data;
  assign mce[3] = if_n2.o_user_rx_check_err; assign mfe[3] = if_n2.o_user_rx_frame_err;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  task automatic drive_bit(input int idx, input logic b);
    line[idx] = b;
    repeat (c_d) @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge; the scoreboard entry carries the expected valid cycle.
  task automatic send_frame(input int idx, input logic [7:0] data, input bit par_en,
                            input logic pbit, input int nstop, input logic stop_val,
                            input logic exp_ce);
    int   n0;
    exp_t e;
    n0     = cyc;
    e.data = data;
    e.ce   = exp_ce;
    e.fe   = ~stop_val;
    e.cyc  = n0 + 3 + c_h + (8 + (par_en ? 1 : 0) + nstop) * c_d + 1;
    sb[idx].push_back(e);
    drive_bit(idx, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(idx, data[i]);
    if (par_en) drive_bit(idx, pbit);
    for (int i = 0; i < nstop; i++) drive_bit(idx, stop_val);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (mv[i] === 1'b1) begin
        if (sb[i].size() == 0) begin
          check($sformatf("unexpected_valid_dut%0d", i), 1, 0);
        end else begin
          e = sb[i].pop_front();
          check($sformatf("data_dut%0d", i), int'(md[i]), int'(e.data));
          check($sformatf("check_err_dut%0d", i), int'(mce[i]), int'(e.ce));
          check($sformatf("frame_err_dut%0d", i), int'(mfe[i]), int'(e.fe));
          check($sformatf("valid_cycle_dut%0d", i), cyc, e.cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    for (int i = 0; i < 4; i++) line[i] = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", int'(if_n1.o_user_rx_data), 0);
    check("rst_valid", int'(if_n1.o_user_rx_valid), 0);
    check("rst_check_err", int'(if_n1.o_user_rx_check_err), 0);
    check("rst_frame_err", int'(if_n1.o_user_rx_frame_err), 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    repeat (20) @(posedge clk); #1;

    send_frame(1, 8'h07, 1'b1, 1'b1, 1, 1'b1, 1'b0);
    send_frame(1, 8'h07, 1'b1, 1'b0, 1, 1'b1, 1'b1);
    send_frame(2, 8'h07, 1'b1, 1'b0, 1, 1'b1, 1'b0);
    repeat (20) @(posedge clk); #1;

    line[0] = 1'b0;
    repeat (3) @(posedge clk); #1;
    line[0] = 1'b1;
    repeat (20) @(posedge clk); #1;
    check("glitch_fsm_idle", int'(dut_n1.state_q), 0);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    repeat (20) @(posedge clk); #1;

    send_frame(0, 8'h55, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    repeat (30 * c_d) @(posedge clk); #1;
    check("break_no_extra_valid", sb[0].size(), 0);
    line[0] = 1'b1;
    repeat (3 * c_d) @(posedge clk); #1;
    send_frame(0, 8'h81, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    repeat (20) @(posedge clk); #1;

    send_frame(0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    send_frame(0, 8'hFF, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    send_frame(3, 8'h00, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    send_frame(3, 8'hFF, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    repeat (20) @(posedge clk); #1;

    // Partial 0x5A frame cut by reset during data bit 4.
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    line[0] = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    line[0] = 1'b1;
    #1;
    check("midrst_data", int'(if_n1.o_user_rx_data), 0);
    check("midrst_valid", int'(if_n1.o_user_rx_valid), 0);
    check("midrst_check_err", int'(if_n1.o_user_rx_check_err), 0);
    check("midrst_frame_err", int'(if_n1.o_user_rx_frame_err), 0);
    check("midrst_fsm_idle", int'(dut_n1.state_q), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) @(posedge clk); #1;
    send_frame(0, 8'hC3, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    repeat (50) @(posedge clk); #1;

    for (int i = 0; i < 4; i++) check($sformatf("missing_valid_dut%0d", i), sb[i].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the UART link; the receive-side counterpart of the team's UART transmitter with identical framing parameters. Samples the serial line `i_uart_rx` and reassembles start, data (LSB first), optional parity and stop bits. Delivers each frame as a one-cycle valid pulse on a valid-only user interface with parity- and framing-error flags. Sits between the board RX pin and user logic, e.g. for loopback against the transmitter.

## Interface
- `P_SYSTEM_CLK`, 50_000_000: clock frequency in Hz.
- `P_UART_BUADRATE`, 9600: line baud rate.
- `P_UART_DATA_WIDTH`, 8: data bits per frame, legal 5..8.
- `P_UART_STOP_WIDTH`, 1: stop bits, legal 1 or 2.
- `P_UART_CHECK`, 0: parity mode; NONE=0, ODD=1, EVEN=2.
- `i_clk`  in  1  system clock. All logic runs in this single clock domain.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_uart_rx`  in  1  serial line; asynchronous to `i_clk`; idles high.
- `o_user_rx_data`  out  P_UART_DATA_WIDTH  received data, bit 0 = first data bit on line.
- `o_user_rx_valid`  out  1  one-cycle pulse per completed frame.
- `o_user_rx_check_err`  out  1  parity mismatch for the delivered frame; 0 when P_UART_CHECK=0.
- `o_user_rx_frame_err`  out  1  at least one stop bit sampled low in the delivered frame.

## Operation
- Derived constants: D = P_SYSTEM_CLK / P_UART_BUADRATE (integer truncation); H = D/2 (truncation); P = 1 if P_UART_CHECK≠0, else 0. Required: 4 ≤ D < 65536. The baud counter is 16 bits.
- Synchronizer: two flops on `i_uart_rx`, reset to 1. One further register feeds the edge detector. A start is a high-to-low transition on the synchronized line.
- FSM states: IDLE, START, DATA, CHECK, STOP.
  - IDLE: baud counter held at 0. A falling edge moves to START with counter = 0.
  - START: count to H-1, then sample. If the sample is low, go to DATA with counter 0. If high (glitch), return to IDLE with no output.
  - DATA: sample when counter = D-1, then clear the counter. Shift the sample into the MSB of the shift register (right shift), so after P_UART_DATA_WIDTH samples bit 0 holds the first bit received. After the last data bit, go to CHECK if P=1, else STOP.
  - CHECK: sample at D-1 and store it as the received parity bit, then go to STOP.
  - STOP: sample at D-1, P_UART_STOP_WIDTH times. Any low sample sets the frame-error accumulator. After the last stop sample, go to IDLE.
- Parity:
  - EVEN: error when XOR(data, parity bit) = 1.
  - ODD: error when XOR(data, parity bit) = 0.
- Output update, in the cycle after the last stop sample:
  - `o_user_rx_valid` = 1 for exactly one cycle.
  - `o_user_rx_data`, `o_user_rx_check_err` and `o_user_rx_frame_err` are loaded in that same cycle and held until the next frame's valid.
  - Frames with errors are still delivered, with the flags set.
- No backpressure: the user must accept data on the valid pulse. A new frame overwrites the outputs.
- After a frame-error frame with the line held low (break), no new frame starts until the line goes high and then falls again. This follows from edge-based start detection.
- Reset values: `o_user_rx_data` = 0, `o_user_rx_valid` = 0, both error flags = 0, FSM in IDLE, all counters 0.
- Reset mid-frame discards the partial frame immediately; no valid pulse is generated for it.

## Timing
- Pin-to-detection: a falling edge on `i_uart_rx` is seen by the FSM 3 `i_clk` cycles later (t0).
- Samples occur at t0+H (start bit), then at t0+H+k·D for k = 1..(N+P+S), where N = P_UART_DATA_WIDTH and S = P_UART_STOP_WIDTH.
- `o_user_rx_valid` is high in cycle t0+H+(N+P+S)·D+1.
- Returning to IDLE mid-stop-bit gives about D/2 of margin for the next start edge. Back-to-back frames with zero idle gap are received without loss.
- Tolerated baud mismatch is at least ±2% at D ≥ 16.

## Test plan
Bench configuration: P_SYSTEM_CLK=1_000_000, P_UART_BUADRATE=100_000, giving D=10 and H=5.
- **8N1 single frame.** Drive 0xA5 with 1 stop bit → exactly one valid pulse; data=0xA5, check_err=0, frame_err=0; valid 3+5+9·10+1 cycles after the pin falls.
- **Parity.** With P_UART_CHECK=2, send 0x07 with parity 1 → check_err=0; the same data with parity 0 → check_err=1. With P_UART_CHECK=1, 0x07 with parity 0 → check_err=0.
- **Glitch rejection.** Pulse the line low for 3 cycles, then hold high → no valid, FSM back in IDLE; a following 0x3C frame is received correctly.
- **Framing error and break.** Send 0x55 with the stop bit low, then hold the line low for 30 bit times → one valid, data=0x55, frame_err=1, no further valid. After the line is released high, a 0x81 frame is received with frame_err=0.
- **Back-to-back.** Send 0x00 then 0xFF with no idle gap → two valids exactly 100 cycles apart, data 0x00 then 0xFF. Repeat with P_UART_STOP_WIDTH=2 → spacing 110 cycles.
- **Reset mid-frame.** Assert `i_rst` during data bit 4 → all outputs 0 immediately, no valid for the partial frame; the next full frame 0xC3 is received correctly.
